// File: rtl/core_scheduler_if.sv
// Handshake bundle between the core scheduler and the fetcher/decoder/LSU/ALU lanes.
// master = scheduler side, slave = core units driving status back.
interface core_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
);
  logic                       start;
  logic                       fetch_done;
  logic                       decoded_ret;
  logic [THREADS-1:0]         thread_en;
  logic [THREADS-1:0]         lsu_busy;
  logic [THREADS*PC_BITS-1:0] next_pc;
  logic [2:0]                 core_state;
  logic                       fetch_req;
  logic [PC_BITS-1:0]         current_pc;
  logic                       diverge;
  logic                       done;

  modport master (
    input  start, fetch_done, decoded_ret, thread_en, lsu_busy, next_pc,
    output core_state, fetch_req, current_pc, diverge, done
  );

  modport slave (
    output start, fetch_done, decoded_ret, thread_en, lsu_busy, next_pc,
    input  core_state, fetch_req, current_pc, diverge, done
  );
endinterface

// File: rtl/core_scheduler.sv
// Per-core instruction-cycle sequencer: steps FETCH..UPDATE, stalls on LSUs, owns the PC.
//  state   | meaning
//  IDLE    | waiting for start
//  FETCH   | fetch_req high until fetch_done
//  DECODE  | decoder latches the instruction
//  REQUEST | LSUs launch
//  WAIT    | stall while any enabled lane's LSU is busy
//  EXECUTE | ALUs register results
//  UPDATE  | advance PC or finish on RET / empty mask
//  DONE    | block finished, held until reset
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input logic              clk,
  input logic              reset,
  core_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t               state, state_nxt;
  logic                 fetch_req, fetch_req_nxt;
  logic [PC_BITS-1:0]   pc, pc_nxt;
  logic                 diverge, diverge_nxt;
  logic                 done, done_nxt;
  logic [PC_BITS-1:0]   pick_pc;
  logic                 mismatch;

  // Lowest-index enabled lane wins; iterate high-to-low so the last hit sticks.
  always_comb begin
    pick_pc  = '0;
    mismatch = 1'b0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (bus.thread_en[i]) pick_pc = bus.next_pc[i*PC_BITS +: PC_BITS];
    end
    for (int i = 0; i < THREADS; i++) begin
      if (bus.thread_en[i] && (bus.next_pc[i*PC_BITS +: PC_BITS] != pick_pc)) mismatch = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_req_nxt = fetch_req;
    pc_nxt        = pc;
    diverge_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt     = S_FETCH;
          fetch_req_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.fetch_done) begin
          state_nxt     = S_DECODE;
          fetch_req_nxt = 1'b0;
        end
      end
      S_DECODE:  state_nxt = S_REQUEST;
      S_REQUEST: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!(|(bus.lsu_busy & bus.thread_en))) state_nxt = S_EXECUTE;
      end
      S_EXECUTE: state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (bus.decoded_ret || (bus.thread_en == '0)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt     = S_FETCH;
          pc_nxt        = pick_pc;
          fetch_req_nxt = 1'b1;
          diverge_nxt   = mismatch;
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_req <= 1'b0;
      pc        <= '0;
      diverge   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_req <= fetch_req_nxt;
      pc        <= pc_nxt;
      diverge   <= diverge_nxt;
      done      <= done_nxt;
    end
  end

  assign bus.core_state = state;
  assign bus.fetch_req  = fetch_req;
  assign bus.current_pc = pc;
  assign bus.diverge    = diverge;
  assign bus.done       = done;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: phase sequencing, LSU stall, PC select, divergence, RET, reset.
module tb_core_scheduler;
  localparam int THREADS = 4;
  localparam int PC_BITS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  core_scheduler_if #(.THREADS(THREADS), .PC_BITS(PC_BITS)) bus ();

  core_scheduler #(.THREADS(THREADS), .PC_BITS(PC_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] tgt, input int max);
    int k = 0;
    while (bus.core_state !== tgt && k < max) begin
      tick();
      k++;
    end
    check_val(tag, {29'd0, bus.core_state}, {29'd0, tgt});
  endtask

  // From FETCH: run one stall-free instruction and stop one cycle after UPDATE.
  task automatic run_instr(input string tag, input logic [3:0] en, input logic [31:0] npc, input logic ret);
    bus.thread_en   = en;
    bus.next_pc     = npc;
    bus.decoded_ret = ret;
    bus.lsu_busy    = '0;
    bus.fetch_done  = 1'b1;
    wait_state(tag, 3'd6, 20);
    tick();
  endtask

  logic [2:0] t1_exp [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

  initial begin
    bus.start       = 1'b0;
    bus.fetch_done  = 1'b0;
    bus.decoded_ret = 1'b0;
    bus.thread_en   = 4'hF;
    bus.lsu_busy    = 4'h0;
    bus.next_pc     = {4{8'h01}};
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_state", {29'd0, bus.core_state}, 32'd0);
    check_val("rst_pc", {24'd0, bus.current_pc}, 32'd0);
    check_val("rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    check_val("rst_diverge", {31'd0, bus.diverge}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    check_val("idle_hold", {29'd0, bus.core_state}, 32'd0);

    // Basic instruction: two FETCH cycles without fetch_done, then 7-cycle loop.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("t1_fetch0", {29'd0, bus.core_state}, 32'd1);
    check_val("t1_freq0", {31'd0, bus.fetch_req}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val("t1_seq", {29'd0, bus.core_state}, {29'd0, t1_exp[k]});
      if (k == 1) bus.fetch_done = 1'b1;
      if (k == 2) check_val("t1_freq_dec", {31'd0, bus.fetch_req}, 32'd0);
    end
    check_val("t1_pc", {24'd0, bus.current_pc}, 32'h01);
    check_val("t1_div", {31'd0, bus.diverge}, 32'd0);
    check_val("t1_freq_upd", {31'd0, bus.fetch_req}, 32'd1);

    // LSU stall: lane 2 busy through the 4th WAIT cycle, released in the 5th.
    bus.lsu_busy = 4'b0100;
    bus.next_pc  = {4{8'h03}};
    wait_state("t2_reach_wait", 3'd4, 10);
    for (int w = 1; w <= 5; w++) begin
      check_val("t2_wait", {29'd0, bus.core_state}, 32'd4);
      if (w == 5) bus.lsu_busy = 4'b0000;
      tick();
    end
    check_val("t2_exec", {29'd0, bus.core_state}, 32'd5);
    tick();
    check_val("t2_upd", {29'd0, bus.core_state}, 32'd6);
    tick();
    check_val("t2_pc", {24'd0, bus.current_pc}, 32'h03);

    // Busy bit of a disabled lane is ignored.
    bus.thread_en = 4'b1011;
    bus.lsu_busy  = 4'b0100;
    wait_state("t3_reach_wait", 3'd4, 10);
    tick();
    check_val("t3_wait_1cyc", {29'd0, bus.core_state}, 32'd5);
    tick();
    check_val("t3_upd", {29'd0, bus.core_state}, 32'd6);

    // Divergence: lane 3 disagrees.
    bus.thread_en = 4'b1111;
    bus.lsu_busy  = 4'b0000;
    bus.next_pc   = {8'h07, 8'h05, 8'h05, 8'h05};
    tick();
    check_val("t5_state", {29'd0, bus.core_state}, 32'd1);
    check_val("t5_pc", {24'd0, bus.current_pc}, 32'h05);
    check_val("t5_div_hi", {31'd0, bus.diverge}, 32'd1);
    tick();
    check_val("t5_div_lo", {31'd0, bus.diverge}, 32'd0);

    run_instr("t5b_upd", 4'b0111, {8'h07, 8'h06, 8'h06, 8'h06}, 1'b0);
    check_val("t5b_pc", {24'd0, bus.current_pc}, 32'h06);
    check_val("t5b_div", {31'd0, bus.diverge}, 32'd0);

    run_instr("t5c_upd", 4'b1010, {8'h0A, 8'h33, 8'h0B, 8'h44}, 1'b0);
    check_val("t5c_pc", {24'd0, bus.current_pc}, 32'h0B);
    check_val("t5c_div", {31'd0, bus.diverge}, 32'd1);

    // PC wrap.
    run_instr("t7a_upd", 4'b1111, {4{8'hFF}}, 1'b0);
    check_val("t7a_pc", {24'd0, bus.current_pc}, 32'hFF);
    run_instr("t7b_upd", 4'b1111, {4{8'h00}}, 1'b0);
    check_val("t7b_pc", {24'd0, bus.current_pc}, 32'h00);
    check_val("t7b_div", {31'd0, bus.diverge}, 32'd0);
    check_val("t7b_state", {29'd0, bus.core_state}, 32'd1);

    // RET finishes the block; start is ignored in DONE.
    run_instr("t4a_upd", 4'b1111, {4{8'h07}}, 1'b0);
    check_val("t4a_pc", {24'd0, bus.current_pc}, 32'h07);
    run_instr("t4b_upd", 4'b1111, {4{8'h55}}, 1'b1);
    check_val("t4_state", {29'd0, bus.core_state}, 32'd7);
    check_val("t4_done", {31'd0, bus.done}, 32'd1);
    check_val("t4_pc", {24'd0, bus.current_pc}, 32'h07);
    check_val("t4_freq", {31'd0, bus.fetch_req}, 32'd0);
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    tick();
    check_val("t4_start_ign", {29'd0, bus.core_state}, 32'd7);
    check_val("t4_done_hold", {31'd0, bus.done}, 32'd1);
    check_val("t4_pc_hold", {24'd0, bus.current_pc}, 32'h07);

    // Reset in WAIT with busy LSUs.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.decoded_ret = 1'b0;
    check_val("t6a_idle", {29'd0, bus.core_state}, 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_instr("t6_upd", 4'b1111, {4{8'h42}}, 1'b0);
    check_val("t6_pc_pre", {24'd0, bus.current_pc}, 32'h42);
    bus.lsu_busy = 4'b1111;
    wait_state("t6_reach_wait", 3'd4, 10);
    bus.start = 1'b1;
    tick();
    check_val("t6_stall", {29'd0, bus.core_state}, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    check_val("t6_state", {29'd0, bus.core_state}, 32'd0);
    check_val("t6_pc", {24'd0, bus.current_pc}, 32'h00);
    check_val("t6_done", {31'd0, bus.done}, 32'd0);
    check_val("t6_freq", {31'd0, bus.fetch_req}, 32'd0);
    tick();
    check_val("t6_idle_hold", {29'd0, bus.core_state}, 32'd0);

    // Empty lane mask at UPDATE also finishes; PC untouched.
    bus.lsu_busy = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_instr("t8_upd", 4'b0000, {4{8'h42}}, 1'b0);
    check_val("t8_state", {29'd0, bus.core_state}, 32'd7);
    check_val("t8_pc", {24'd0, bus.current_pc}, 32'h00);
    check_val("t8_done", {31'd0, bus.done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
